soc_system_onchip_memory_arbiter: RTL and testbench



---
 rtl/soc_system_onchip_memory_arbiter_if.sv | 22 ++
 rtl/soc_system_onchip_memory_arbiter.sv | 105 ++++++++++
 tb/tb_soc_system_onchip_memory_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_system_onchip_memory_arbiter_if.sv
// Avalon-MM port bundle between one bus master and the on-chip memory arbiter.
// The arbiter connects to the slave modport; the master side drives requests.
interface soc_system_onchip_memory_arbiter_if;
  logic [16:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic        readdatavalid;
  logic [31:0] readdata;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdatavalid, readdata
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdatavalid, readdata
  );
endinterface

// File: rtl/soc_system_onchip_memory_arbiter.sv
// Two-master round-robin arbiter with bounded hold in front of a single-port
// on-chip RAM (registered address, one-cycle read latency, clock-enable gated).
module soc_system_onchip_memory_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  soc_system_onchip_memory_arbiter_if.slave m0,
  soc_system_onchip_memory_arbiter_if.slave m1,
  output logic [16:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic        mem_clken,
  input  logic [31:0] mem_readdata
);
  localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX);

  logic       r_owner;
  logic [7:0] r_hold_cnt;
  logic       r_rdv0;
  logic       r_rdv1;

  logic       w_req0;
  logic       w_req1;
  logic       w_hold_ok;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_gnt_any;

  // Request decode and grant: owner keeps the port until its hold budget runs out
  always_comb begin
    w_req0    = m0.read | m0.write;
    w_req1    = m1.read | m1.write;
    w_hold_ok = (r_hold_cnt < HOLD_LIMIT);
    w_gnt0    = 1'b0;
    w_gnt1    = 1'b0;
    if (reset) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end else if (w_req0 && w_req1) begin
      if (w_hold_ok) begin
        w_gnt0 = ~r_owner;
        w_gnt1 = r_owner;
      end else begin
        w_gnt0 = r_owner;
        w_gnt1 = ~r_owner;
      end
    end else begin
      w_gnt0 = w_req0;
      w_gnt1 = w_req1;
    end
    w_gnt_any = w_gnt0 | w_gnt1;
  end

  // Master handshakes and RAM port mux; idle cycles drop clken so q stays put
  always_comb begin
    m0.waitrequest   = ~w_gnt0;
    m1.waitrequest   = ~w_gnt1;
    m0.readdatavalid = r_rdv0 & ~reset;
    m1.readdatavalid = r_rdv1 & ~reset;
    m0.readdata      = mem_readdata;
    m1.readdata      = mem_readdata;
    mem_chipselect   = w_gnt_any;
    mem_clken        = w_gnt_any;
    if (w_gnt1) begin
      mem_address    = m1.address;
      mem_byteenable = m1.byteenable;
      mem_writedata  = m1.writedata;
      mem_write      = m1.write;
    end else begin
      mem_address    = m0.address;
      mem_byteenable = m0.byteenable;
      mem_writedata  = m0.writedata;
      mem_write      = w_gnt0 & m0.write;
    end
  end

  // Ownership, saturating hold counter and read-valid pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner    <= 1'b0;
      r_hold_cnt <= 8'd0;
      r_rdv0     <= 1'b0;
      r_rdv1     <= 1'b0;
    end else begin
      // A simultaneous read+write is a write and returns no data
      r_rdv0 <= w_gnt0 & m0.read & ~m0.write;
      r_rdv1 <= w_gnt1 & m1.read & ~m1.write;
      if (!w_gnt_any) begin
        r_hold_cnt <= 8'd0;
      end else if (w_gnt1 == r_owner) begin
        if (r_hold_cnt != 8'hFF) begin
          r_hold_cnt <= r_hold_cnt + 8'd1;
        end else begin
          r_hold_cnt <= r_hold_cnt;
        end
      end else begin
        r_owner    <= w_gnt1;
        r_hold_cnt <= 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_soc_system_onchip_memory_arbiter.sv
// Randomized scoreboard bench: a queue-based reference model predicts grants and
// read data; a negedge monitor pops expected read responses and compares.
module tb_soc_system_onchip_memory_arbiter;
  localparam int  HOLD_A = 4;
  localparam time PERIOD = 10;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [16:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } op_t;

  typedef struct {
    time         due;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset_b = 1'b1;
  always #5 clk = ~clk;

  soc_system_onchip_memory_arbiter_if ifa0();
  soc_system_onchip_memory_arbiter_if ifa1();
  soc_system_onchip_memory_arbiter_if ifb0();
  soc_system_onchip_memory_arbiter_if ifb1();

  logic [16:0] a_mem_address;
  logic [3:0]  a_mem_byteenable;
  logic [31:0] a_mem_writedata;
  logic        a_mem_chipselect, a_mem_write, a_mem_clken;
  logic [31:0] a_mem_readdata;
  logic [16:0] b_mem_address;
  logic [3:0]  b_mem_byteenable;
  logic [31:0] b_mem_writedata;
  logic        b_mem_chipselect, b_mem_write, b_mem_clken;
  logic [31:0] b_mem_readdata;
  assign b_mem_readdata = 32'd0;

  soc_system_onchip_memory_arbiter #(.HOLD_MAX(HOLD_A)) dut_a (
    .clk(clk), .reset(reset), .m0(ifa0.slave), .m1(ifa1.slave),
    .mem_address(a_mem_address), .mem_byteenable(a_mem_byteenable),
    .mem_writedata(a_mem_writedata), .mem_chipselect(a_mem_chipselect),
    .mem_write(a_mem_write), .mem_clken(a_mem_clken), .mem_readdata(a_mem_readdata)
  );

  soc_system_onchip_memory_arbiter #(.HOLD_MAX(1)) dut_b (
    .clk(clk), .reset(reset_b), .m0(ifb0.slave), .m1(ifb1.slave),
    .mem_address(b_mem_address), .mem_byteenable(b_mem_byteenable),
    .mem_writedata(b_mem_writedata), .mem_chipselect(b_mem_chipselect),
    .mem_write(b_mem_write), .mem_clken(b_mem_clken), .mem_readdata(b_mem_readdata)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Behavioural single-port RAM: registered address, unregistered q, clock enable
  logic [31:0] ram_mem [0:1023];
  logic [9:0]  ram_addr_r = 10'd0;
  always @(posedge clk) begin
    if (a_mem_clken) begin
      if (a_mem_chipselect && a_mem_write)
        ram_mem[a_mem_address[9:0]] <= merge(ram_mem[a_mem_address[9:0]], a_mem_writedata, a_mem_byteenable);
      ram_addr_r <= a_mem_address[9:0];
    end
  end
  assign a_mem_readdata = ram_mem[ram_addr_r];

  int          n_cmp = 0;
  int          n_bad = 0;
  op_t         sq0[$], sq1[$];
  exp_t        eq0[$], eq1[$];
  int          glog[$];
  op_t         cur0, cur1;
  logic        have0 = 1'b0, have1 = 1'b0;
  logic        rst_next = 1'b1;
  int          m_owner = 0, m_run = 0;
  logic [31:0] ref_mem [0:1023];
  logic [31:0] last_rd0 = 32'd0, last_rd1 = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic op_t mk(input logic rd, input logic wr, input logic [16:0] addr,
                             input logic [3:0] be, input logic [31:0] data);
    op_t o;
    o.rd = rd; o.wr = wr; o.addr = addr; o.be = be; o.data = data;
    return o;
  endfunction

  // Monitor: read responses must arrive exactly when the scoreboard says so
  always @(negedge clk) begin : mon
    logic hit0, hit1;
    hit0 = (eq0.size() > 0) && (eq0[0].due == $time);
    hit1 = (eq1.size() > 0) && (eq1[0].due == $time);
    chk("rdv0", {31'd0, ifa0.readdatavalid}, {31'd0, hit0});
    chk("rdv1", {31'd0, ifa1.readdatavalid}, {31'd0, hit1});
    if (hit0) begin
      chk("rdata0", ifa0.readdata, eq0[0].data);
      void'(eq0.pop_front());
    end
    if (hit1) begin
      chk("rdata1", ifa1.readdata, eq1[0].data);
      void'(eq1.pop_front());
    end
    if (ifa0.readdatavalid) last_rd0 = ifa0.readdata;
    if (ifa1.readdatavalid) last_rd1 = ifa1.readdata;
  end

  task automatic drive(input op_t o0, input op_t o1);
    ifa0.read = o0.rd; ifa0.write = o0.wr; ifa0.address = o0.addr;
    ifa0.byteenable = o0.be; ifa0.writedata = o0.data;
    ifa1.read = o1.rd; ifa1.write = o1.wr; ifa1.address = o1.addr;
    ifa1.byteenable = o1.be; ifa1.writedata = o1.data;
  endtask

  // One clock cycle: present held/new requests, predict grant, check, update model
  task automatic step();
    logic rst_now, req0, req1;
    int   g, og;
    op_t  gop;
    exp_t e;
    @(posedge clk); #1;
    rst_now = rst_next;
    reset = rst_now;
    if (rst_now) begin
      eq0.delete();
      eq1.delete();
    end
    if (!have0) begin
      if (sq0.size() > 0) cur0 = sq0.pop_front(); else cur0 = '0;
    end
    if (!have1) begin
      if (sq1.size() > 0) cur1 = sq1.pop_front(); else cur1 = '0;
    end
    drive(cur0, cur1);
    req0 = cur0.rd | cur0.wr;
    req1 = cur1.rd | cur1.wr;
    g = -1;
    if (!rst_now) begin
      if (req0 && req1) g = (m_run < HOLD_A) ? m_owner : 1 - m_owner;
      else if (req0) g = 0;
      else if (req1) g = 1;
    end
    gop = (g == 1) ? cur1 : cur0;
    @(negedge clk);
    og = (req0 && !ifa0.waitrequest) ? 0 : ((req1 && !ifa1.waitrequest) ? 1 : -1);
    glog.push_back(og);
    if (req0 || rst_now) chk("wait0", {31'd0, ifa0.waitrequest}, {31'd0, (g != 0)});
    if (req1 || rst_now) chk("wait1", {31'd0, ifa1.waitrequest}, {31'd0, (g != 1)});
    chk("chipselect", {31'd0, a_mem_chipselect}, {31'd0, (g >= 0)});
    chk("clken", {31'd0, a_mem_clken}, {31'd0, (g >= 0)});
    if (g >= 0) begin
      chk("mem_address", {15'd0, a_mem_address}, {15'd0, gop.addr});
      chk("mem_write", {31'd0, a_mem_write}, {31'd0, gop.wr});
    end else begin
      chk("mem_write_idle", {31'd0, a_mem_write}, 32'd0);
    end
    if (rst_now) begin
      m_owner = 0;
      m_run = 0;
    end else if (g >= 0) begin
      if (g == m_owner) begin
        if (m_run < 255) m_run++;
      end else begin
        m_owner = g;
        m_run = 1;
      end
      if (gop.wr) begin
        ref_mem[gop.addr[9:0]] = merge(ref_mem[gop.addr[9:0]], gop.data, gop.be);
      end else begin
        e.due = $time + PERIOD;
        e.data = ref_mem[gop.addr[9:0]];
        if (g == 0) eq0.push_back(e); else eq1.push_back(e);
      end
    end else begin
      m_run = 0;
    end
    have0 = req0 && (g != 0);
    have1 = req1 && (g != 1);
  endtask

  task automatic run_ops();
    int guard;
    guard = 0;
    while ((sq0.size() > 0 || sq1.size() > 0 || have0 || have1) && guard < 5000) begin
      step();
      guard++;
    end
    if (guard >= 5000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d cycles, required under 5000", guard);
    end
    step();
    step();
  endtask

  task automatic pulse_reset();
    rst_next = 1'b1;
    step();
    rst_next = 1'b0;
  endtask

  int cseq[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
  int iseq[9] = '{0, 0, 0, -1, 0, 0, 0, 0, 1};
  int bseq[6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    int og;
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    drive('0, '0);
    ifb0.read = 1'b1; ifb0.write = 1'b0; ifb0.address = 17'd1;
    ifb0.byteenable = 4'd0; ifb0.writedata = 32'd0;
    ifb1.read = 1'b1; ifb1.write = 1'b0; ifb1.address = 17'd2;
    ifb1.byteenable = 4'd0; ifb1.writedata = 32'd0;

    // Reset held 3 cycles with both masters requesting; m0 wins first
    sq0.push_back(mk(1'b1, 1'b0, 17'd5, 4'hF, 32'd0));
    sq1.push_back(mk(1'b1, 1'b0, 17'd6, 4'hF, 32'd0));
    rst_next = 1'b1;
    repeat (3) step();
    rst_next = 1'b0;
    glog.delete();
    run_ops();
    chk("first_grant", glog[0], 32'd0);
    chk("second_grant", glog[1], 32'd1);

    // Single master write then read of the same word
    glog.delete();
    sq1.push_back(mk(1'b0, 1'b1, 17'h00010, 4'hF, 32'hDEADBEEF));
    sq1.push_back(mk(1'b1, 1'b0, 17'h00010, 4'hF, 32'd0));
    run_ops();
    chk("single_wr_grant", glog[0], 32'd1);
    chk("single_rd_grant", glog[1], 32'd1);
    chk("single_rdata", last_rd1, 32'hDEADBEEF);

    // Continuous contention, hold budget 4
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      sq0.push_back(mk(1'b1, 1'b0, 17'($urandom_range(0, 31)), 4'hF, 32'd0));
      sq1.push_back(mk(1'b1, 1'b0, 17'($urandom_range(0, 31)), 4'hF, 32'd0));
    end
    glog.delete();
    run_ops();
    for (int i = 0; i < 9; i++) chk("contention_seq", glog[i], cseq[i]);

    // Idle cycle restarts the hold count
    pulse_reset();
    repeat (3) sq0.push_back(mk(1'b1, 1'b0, 17'd7, 4'hF, 32'd0));
    sq0.push_back('0);
    repeat (5) sq0.push_back(mk(1'b1, 1'b0, 17'd8, 4'hF, 32'd0));
    repeat (4) sq1.push_back('0);
    repeat (5) sq1.push_back(mk(1'b1, 1'b0, 17'd9, 4'hF, 32'd0));
    glog.delete();
    run_ops();
    for (int i = 0; i < 9; i++) chk("idle_hold_seq", glog[i], iseq[i]);

    // Byte-lane merge across masters
    sq0.push_back(mk(1'b0, 1'b1, 17'd20, 4'hF, 32'h11223344));
    sq0.push_back('0);
    sq0.push_back(mk(1'b1, 1'b0, 17'd20, 4'hF, 32'd0));
    sq1.push_back('0);
    sq1.push_back(mk(1'b0, 1'b1, 17'd20, 4'b0101, 32'hAABBCCDD));
    run_ops();
    chk("byte_merge", last_rd0, 32'h11BB33DD);

    // Read accepted, then reset in the data cycle: no response, later read fine
    sq0.push_back(mk(1'b1, 1'b0, 17'd20, 4'hF, 32'd0));
    step();
    rst_next = 1'b1;
    step();
    rst_next = 1'b0;
    last_rd0 = 32'd0;
    sq0.push_back(mk(1'b1, 1'b0, 17'd20, 4'hF, 32'd0));
    run_ops();
    chk("post_reset_read", last_rd0, 32'h11BB33DD);

    // Randomized mixed traffic on a small address window
    for (int i = 0; i < 300; i++) begin
      int r0, r1;
      r0 = $urandom_range(0, 9);
      r1 = $urandom_range(0, 9);
      sq0.push_back(mk(r0 >= 3 && r0 < 6 || r0 == 9, r0 >= 6, 17'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), $urandom));
      sq1.push_back(mk(r1 >= 3 && r1 < 6 || r1 == 9, r1 >= 6, 17'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), $urandom));
    end
    run_ops();
    chk("scoreboard_empty", eq0.size() + eq1.size(), 32'd0);

    // HOLD_MAX=1 instance must alternate strictly
    @(posedge clk); #1;
    reset_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      og = !ifb0.waitrequest ? 0 : (!ifb1.waitrequest ? 1 : -1);
      chk("alt_seq", og, bseq[i]);
      chk("alt_rdv_excl", {31'd0, ifb0.readdatavalid & ifb1.readdatavalid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
